// File: rtl/simt_warp_scheduler_pkg.sv
// Shared opcode, operand-select and instruction-field definitions for the
// multi-warp SIMT scheduler.
package simt_warp_scheduler_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BRA  = 4'hB;
    localparam logic [3:0] OP_PUSH = 4'hC;
    localparam logic [3:0] OP_ELSE = 4'hD;
    localparam logic [3:0] OP_POP  = 4'hE;
    localparam logic [3:0] OP_EXIT = 4'hF;

    localparam logic [1:0] S2_REG = 2'd0;
    localparam logic [1:0] S2_MEM = 2'd1;
    localparam logic [1:0] S2_IMM = 2'd2;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int X_LSB   = 24;
    localparam int Y_LSB   = 20;
    localparam int Z_LSB   = 16;
    localparam int IMM_MSB = 15;

endpackage

// File: rtl/simt_warp_scheduler_pstack.sv
// Per-warp predicate-mask stack: push/pop/complement with top and below views
// (all-ones when not present) and overflow/underflow strobes.
module warp_pstack
    import simt_warp_scheduler_pkg::*;
#(
    parameter int N_CORES = 8,
    parameter int DEPTH   = 4,
    parameter int DW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               complement,
    input  logic [N_CORES-1:0] push_data,
    output logic [N_CORES-1:0] top_mask,
    output logic [N_CORES-1:0] below_mask,
    output logic [DW-1:0]      depth,
    output logic               ovf,
    output logic               unf
);

    localparam int unsigned ND = DEPTH;

    logic [N_CORES-1:0] entries [DEPTH];
    logic full, empty;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);
    assign ovf   = push && full;
    assign unf   = (pop || complement) && empty;

    always_comb begin
        top_mask   = '1;
        below_mask = '1;
        for (int unsigned i = 0; i < ND; i++) begin
            if (32'(depth) == i + 1) top_mask   = entries[i];
            if (32'(depth) == i + 2) below_mask = entries[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push && !full) begin
            for (int unsigned i = 0; i < ND; i++)
                if (32'(depth) == i) entries[i] <= push_data;
            depth <= depth + DW'(1);
        end else if (complement && !empty) begin
            for (int unsigned i = 0; i < ND; i++)
                if (32'(depth) == i + 1) entries[i] <= ~top_mask & below_mask;
        end else if (pop && !empty) begin
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/simt_warp_scheduler.sv
// Multi-warp SIMT fetch/issue scheduler with round-robin warp switching and
// per-warp predicate stacks. Optional PRED_SKIP_EN: branch over fully-masked blocks.
module simt_warp_scheduler
    import simt_warp_scheduler_pkg::*;
#(
    parameter int N_CORES            = 8,
    parameter int N_WARPS            = 4,
    parameter int PSTACK_DEPTH       = 4,
    parameter int INSTMEM_ADDR_WIDTH = 16,
    parameter int INST_LENGTH        = 32,
    parameter int WID_W              = (N_WARPS > 1) ? $clog2(N_WARPS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [INSTMEM_ADDR_WIDTH-1:0] inst_addr,
    input  logic [INST_LENGTH-1:0]        inst,
    output logic [3:0]                    x,
    output logic [3:0]                    y,
    output logic [3:0]                    z,
    output logic [15:0]                   I,
    output logic [WID_W-1:0]              warp_id,
    output logic                          reg_we,
    output logic [3:0]                    aluc,
    output logic [1:0]                    s2,
    output logic                          MRead,
    output logic                          MWrite,
    input  logic                          MReady,
    output logic [N_CORES-1:0]            en_mask,
    input  logic [N_CORES-1:0]            p_array,
    output logic                          done,
    output logic                          pstack_err
);

    localparam int          DW = $clog2(PSTACK_DEPTH + 1);
    localparam int unsigned NW = N_WARPS;

    logic [INSTMEM_ADDR_WIDTH-1:0] pc [N_WARPS];
    logic [N_WARPS-1:0]            active, active_next;
    logic [WID_W-1:0]              cur_warp, next_warp;
    logic [N_CORES-1:0]            top_m [N_WARPS];
    logic [N_CORES-1:0]            below_m [N_WARPS];
    logic [DW-1:0]                 depth [N_WARPS];
    logic [N_WARPS-1:0]            ovf, unf, push_v, pop_v, comp_v;
    logic [N_CORES-1:0]            cur_m, cur_b, push_data;
    logic [DW-1:0]                 cur_depth;
    logic [INSTMEM_ADDR_WIDTH-1:0] cur_pc, next_pc, imm_addr;
    logic [3:0]                    op;
    logic issue, complete, is_exit, do_push, do_pop, do_comp, any_left;
    logic unused_ok;

    always_comb begin
        cur_pc    = '0;
        cur_m     = '1;
        cur_b     = '1;
        cur_depth = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (32'(cur_warp) == i) begin
                cur_pc    = pc[i];
                cur_m     = top_m[i];
                cur_b     = below_m[i];
                cur_depth = depth[i];
            end
        end
    end

    assign op        = inst[OP_MSB:OP_LSB];
    assign x         = inst[X_LSB+3:X_LSB];
    assign y         = inst[Y_LSB+3:Y_LSB];
    assign z         = inst[Z_LSB+3:Z_LSB];
    assign I         = inst[IMM_MSB:0];
    assign imm_addr  = INSTMEM_ADDR_WIDTH'(inst[IMM_MSB:0]);
    assign issue     = !done;
    assign push_data = cur_m & p_array;
    assign inst_addr = cur_pc;
    assign warp_id   = cur_warp;
    assign en_mask   = done ? '0 : cur_m;
    assign unused_ok = ^cur_depth;

    always_comb begin
        reg_we   = 1'b0;
        aluc     = 4'h0;
        s2       = S2_REG;
        MRead    = 1'b0;
        MWrite   = 1'b0;
        complete = issue;
        next_pc  = cur_pc + INSTMEM_ADDR_WIDTH'(1);
        is_exit  = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        do_comp  = 1'b0;
        case (op)
            OP_NOP: ;
            OP_LDI: begin
                reg_we = 1'b1;
                s2     = S2_IMM;
            end
            OP_LD: begin
                MRead    = 1'b1;
                s2       = S2_MEM;
                reg_we   = MReady;
                complete = issue && MReady;
            end
            OP_ST: begin
                MWrite   = 1'b1;
                complete = issue && MReady;
            end
            OP_BRA:  next_pc = imm_addr;
            OP_PUSH: begin
                do_push = 1'b1;
`ifdef PRED_SKIP_EN
                if (push_data == '0 && cur_depth != DW'(PSTACK_DEPTH)) next_pc = imm_addr;
`endif
            end
            OP_ELSE: begin
                do_comp = 1'b1;
`ifdef PRED_SKIP_EN
                if (cur_depth != '0 && (~cur_m & cur_b) == '0) next_pc = imm_addr;
`endif
            end
            OP_POP:  do_pop  = 1'b1;
            OP_EXIT: is_exit = 1'b1;
            default: begin
                reg_we = 1'b1;
                aluc   = {1'b0, op[2:0]};
            end
        endcase
        if (done) begin
            reg_we = 1'b0;
            MRead  = 1'b0;
            MWrite = 1'b0;
        end
    end

    // Search starts just after cur_warp and wraps onto it last, so a lone
    // active warp keeps itself; an exiting warp is already excluded.
    always_comb begin
        active_next = active;
        for (int unsigned i = 0; i < NW; i++)
            if (is_exit && 32'(cur_warp) == i) active_next[i] = 1'b0;
        next_warp = cur_warp;
        any_left  = 1'b0;
        for (int unsigned k = 1; k <= NW; k++) begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (!any_left && active_next[j] && j == (32'(cur_warp) + k) % NW) begin
                    next_warp = WID_W'(j);
                    any_left  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_v = '0;
        pop_v  = '0;
        comp_v = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (issue && 32'(cur_warp) == i) begin
                push_v[i] = do_push;
                pop_v[i]  = do_pop;
                comp_v[i] = do_comp;
            end
        end
    end

    for (genvar w = 0; w < N_WARPS; w++) begin : g_stack
        warp_pstack #(
            .N_CORES(N_CORES),
            .DEPTH  (PSTACK_DEPTH),
            .DW     (DW)
        ) u_pstack (
            .clk       (clk),
            .reset     (reset),
            .push      (push_v[w]),
            .pop       (pop_v[w]),
            .complement(comp_v[w]),
            .push_data (push_data),
            .top_mask  (top_m[w]),
            .below_mask(below_m[w]),
            .depth     (depth[w]),
            .ovf       (ovf[w]),
            .unf       (unf[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NW; i++) pc[i] <= '0;
            active     <= '1;
            cur_warp   <= '0;
            done       <= 1'b0;
            pstack_err <= 1'b0;
        end else begin
            if (|(ovf | unf)) pstack_err <= 1'b1;
            if (complete) begin
                for (int unsigned i = 0; i < NW; i++)
                    if (32'(cur_warp) == i && !is_exit) pc[i] <= next_pc;
                active   <= active_next;
                cur_warp <= next_warp;
                if (!any_left) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simt_warp_scheduler.sv
// Scoreboard bench: a 4-warp and a 1-warp scheduler driven from per-warp
// instruction tables; expected values queued per cycle and checked off-edge.
module tb_simt_warp_scheduler;
    import simt_warp_scheduler_pkg::*;

    localparam int F_WID = 0, F_ADDR = 1, F_WE = 2, F_MR = 3, F_EN = 4,
                   F_DONE = 5, F_ERR = 6, F_ALUC = 7, F_S2 = 8, F_X = 9;
`ifdef PRED_SKIP_EN
    localparam logic [15:0] SKIP_ADDR = 16'h0020;
`else
    localparam logic [15:0] SKIP_ADDR = 16'h0001;
`endif

    logic        clk = 1'b0, reset = 1'b1, MReady = 1'b0;
    logic [7:0]  p_array = '0;
    logic [15:0] addr4, addr1, i4, i1;
    logic [31:0] inst4, inst1;
    logic [3:0]  x4, y4, z4, x1, y1, z1, aluc4, aluc1;
    logic [1:0]  wid4, s24, s21;
    logic        wid1, we4, we1, mr4, mr1, mw4, mw1, done4, done1, err4, err1;
    logic [7:0]  en4, en1;
    logic [31:0] mem4 [4][64];
    logic [31:0] mem1 [64];

    typedef struct { bit d1; int f; logic [31:0] v; string tag; } exp_t;
    exp_t sbq[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign inst4 = mem4[wid4][addr4[5:0]];
    assign inst1 = mem1[addr1[5:0]];

    simt_warp_scheduler #(.N_WARPS(4), .PSTACK_DEPTH(2)) u_dut4 (
        .clk(clk), .reset(reset), .inst_addr(addr4), .inst(inst4), .x(x4), .y(y4), .z(z4),
        .I(i4), .warp_id(wid4), .reg_we(we4), .aluc(aluc4), .s2(s24), .MRead(mr4),
        .MWrite(mw4), .MReady(MReady), .en_mask(en4), .p_array(p_array), .done(done4),
        .pstack_err(err4));

    simt_warp_scheduler #(.N_WARPS(1), .PSTACK_DEPTH(2)) u_dut1 (
        .clk(clk), .reset(reset), .inst_addr(addr1), .inst(inst1), .x(x1), .y(y1), .z(z1),
        .I(i1), .warp_id(wid1), .reg_we(we1), .aluc(aluc1), .s2(s21), .MRead(mr1),
        .MWrite(mw1), .MReady(MReady), .en_mask(en1), .p_array(p_array), .done(done1),
        .pstack_err(err1));

    function automatic logic [31:0] enc(logic [3:0] op, logic [15:0] imm);
        return {op, 12'h123, imm};
    endfunction

    function automatic logic [31:0] observe(bit d1, int f);
        case (f)
            F_WID:   return d1 ? 32'(wid1)  : 32'(wid4);
            F_ADDR:  return d1 ? 32'(addr1) : 32'(addr4);
            F_WE:    return d1 ? 32'(we1)   : 32'(we4);
            F_MR:    return d1 ? 32'(mr1)   : 32'(mr4);
            F_EN:    return d1 ? 32'(en1)   : 32'(en4);
            F_DONE:  return d1 ? 32'(done1) : 32'(done4);
            F_ERR:   return d1 ? 32'(err1)  : 32'(err4);
            F_ALUC:  return d1 ? 32'(aluc1) : 32'(aluc4);
            F_S2:    return d1 ? 32'(s21)   : 32'(s24);
            default: return d1 ? 32'(x1)    : 32'(x4);
        endcase
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_sig(bit d1, int f, logic [31:0] v, string tag);
        exp_t e;
        e.d1 = d1; e.f = f; e.v = v; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_eq(e.tag, observe(e.d1, e.f), e.v);
        end
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int w = 0; w < 4; w++)
            for (int a = 0; a < 64; a++) mem4[w][a] = enc(OP_NOP, 16'h0);
        for (int a = 0; a < 64; a++) mem1[a] = enc(OP_NOP, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state and round-robin over NOPs
        clear_mem();
        do_reset();
        expect_sig(0, F_DONE, 0, "rst_done");
        expect_sig(0, F_ERR, 0, "rst_err");
        expect_sig(0, F_EN, 32'hFF, "rst_en");
        expect_sig(0, F_MR, 0, "rst_mread");
        for (int c = 0; c < 5; c++) begin
            expect_sig(0, F_WID, 32'(c % 4), "rr_wid");
            expect_sig(0, F_ADDR, 32'(c / 4), "rr_addr");
            step();
        end

        // LD stall on warp 0, then reset during warp 1's pending LD
        clear_mem();
        for (int w = 0; w < 4; w++) mem4[w][0] = enc(OP_LD, 16'h0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            MReady = (c == 3);
            expect_sig(0, F_MR, 1, "stall_mread");
            expect_sig(0, F_WE, (c == 3) ? 1 : 0, "stall_we");
            expect_sig(0, F_WID, 0, "stall_wid");
            step();
        end
        MReady = 1'b0;
        expect_sig(0, F_WID, 1, "stall_next_wid");
        expect_sig(0, F_ADDR, 0, "stall_next_addr");
        step();
        mem4[0][0] = enc(OP_NOP, 16'h0);
        do_reset();
        expect_sig(0, F_MR, 0, "rst_ld_mread");
        expect_sig(0, F_WID, 0, "rst_ld_wid");
        step();

        // EXIT of warps 1,3 then 0,2
        clear_mem();
        for (int w = 0; w < 4; w += 2) begin
            mem4[w][0] = enc(OP_LDI, 16'h5);
            mem4[w][1] = enc(OP_LDI, 16'h6);
            mem4[w][2] = enc(OP_EXIT, 16'h0);
        end
        mem4[1][0] = enc(OP_EXIT, 16'h0);
        mem4[3][0] = enc(OP_EXIT, 16'h0);
        do_reset();
        expect_sig(0, F_S2, 32'(S2_IMM), "ldi_s2");
        expect_sig(0, F_ALUC, 0, "ldi_aluc");
        expect_sig(0, F_WE, 1, "ldi_we");
        begin
            int wseq [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
            int aseq [8] = '{0, 0, 0, 0, 1, 1, 2, 2};
            for (int c = 0; c < 8; c++) begin
                expect_sig(0, F_WID, 32'(wseq[c]), "exit_wid");
                expect_sig(0, F_ADDR, 32'(aseq[c]), "exit_addr");
                expect_sig(0, F_DONE, 0, "exit_not_done");
                step();
            end
        end
        mem4[2][2] = enc(OP_LDI, 16'h7);
        expect_sig(0, F_DONE, 1, "done_set");
        expect_sig(0, F_WE, 0, "done_we");
        expect_sig(0, F_EN, 0, "done_en");
        expect_sig(0, F_ADDR, 2, "done_addr");
        step();

        // Divergence on the single-warp instance
        clear_mem();
        mem1[0] = enc(OP_PUSH, 16'h0);
        mem1[1] = enc(OP_ELSE, 16'h0);
        mem1[2] = enc(OP_POP, 16'h0);
        mem1[3] = enc(4'h5, 16'h0);
        p_array = 8'h0F;
        do_reset();
        expect_sig(1, F_EN, 32'hFF, "div_en0");
        step();
        expect_sig(1, F_EN, 32'h0F, "div_push");
        step();
        expect_sig(1, F_EN, 32'hF0, "div_else");
        step();
        expect_sig(1, F_EN, 32'hFF, "div_pop");
        expect_sig(1, F_ADDR, 3, "div_addr");
        expect_sig(1, F_WE, 1, "alu_we");
        expect_sig(1, F_ALUC, 5, "alu_aluc");
        expect_sig(1, F_S2, 32'(S2_REG), "alu_s2");
        expect_sig(1, F_X, 1, "alu_x");
        expect_sig(1, F_ERR, 0, "div_err");
        step();

        // Overflow at depth 2
        clear_mem();
        for (int a = 0; a < 3; a++) mem1[a] = enc(OP_PUSH, 16'h0);
        mem1[3] = enc(OP_POP, 16'h0);
        mem1[4] = enc(OP_POP, 16'h0);
        do_reset();
        begin
            logic [7:0] pin [6] = '{8'h3C, 8'h0F, 8'h04, 8'h00, 8'h00, 8'h00};
            logic [7:0] een [6] = '{8'hFF, 8'h3C, 8'h0C, 8'h0C, 8'h3C, 8'hFF};
            int         eer [6] = '{0, 0, 0, 1, 1, 1};
            for (int c = 0; c < 6; c++) begin
                p_array = pin[c];
                expect_sig(1, F_EN, 32'(een[c]), "ovf_en");
                expect_sig(1, F_ERR, 32'(eer[c]), "ovf_err");
                expect_sig(1, F_ADDR, 32'(c), "ovf_addr");
                step();
            end
        end

        // Underflow POP, then BRA
        clear_mem();
        mem1[0] = enc(OP_POP, 16'h0);
        mem1[1] = enc(OP_BRA, 16'h0010);
        do_reset();
        expect_sig(1, F_ERR, 0, "unf_err0");
        step();
        expect_sig(1, F_ERR, 1, "unf_err");
        expect_sig(1, F_EN, 32'hFF, "unf_en");
        expect_sig(1, F_ADDR, 1, "unf_addr");
        step();
        expect_sig(1, F_ADDR, 32'h10, "bra_addr");
        step();

        // Fully-masked PUSH: skip when enabled, fall through otherwise
        clear_mem();
        mem1[0]    = enc(OP_PUSH, 16'h0020);
        mem1[1]    = enc(OP_POP, 16'h0);
        mem1[6'h20] = enc(OP_POP, 16'h0);
        p_array = 8'h00;
        do_reset();
        expect_sig(1, F_ADDR, 0, "skip_addr0");
        step();
        expect_sig(1, F_ADDR, 32'(SKIP_ADDR), "skip_addr");
        expect_sig(1, F_EN, 0, "skip_en");
        step();
        expect_sig(1, F_EN, 32'hFF, "skip_pop_en");
        expect_sig(1, F_ERR, 0, "skip_err");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
